// File: rtl/s_box_arbiter_if.sv
// Handshake and S-box bus bundle shared between the requesters, the
// arbiter and the external 128-bit S-box bank.
interface s_box_arbiter_if;
  logic         rnd_req;
  logic [127:0] rnd_data;
  logic         rnd_grant;
  logic         rnd_valid;
  logic [127:0] rnd_result;
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_grant;
  logic         key_valid;
  logic [31:0]  key_result;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic         busy;

  // Arbiter side
  modport slave (
    input  rnd_req, rnd_data, key_req, key_word, sb_out,
    output rnd_grant, rnd_valid, rnd_result,
           key_grant, key_valid, key_result, sb_in, busy
  );

  // Requester / S-box bank side
  modport master (
    output rnd_req, rnd_data, key_req, key_word, sb_out,
    input  rnd_grant, rnd_valid, rnd_result,
           key_grant, key_valid, key_result, sb_in, busy
  );
endinterface

// File: rtl/s_box_arbiter.sv
// Time-shares one combinational 128-bit S-box bank between the round
// datapath (SubBytes) and the key scheduler (SubWord) with round-robin
// arbitration, a one-cycle evaluation stage and a registered result.
module s_box_arbiter (
  input  logic            clk,
  input  logic            rst,
  s_box_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_RND = 1'b0,
    SRC_KEY = 1'b1
  } src_e;

  state_e       state_q, state_d;
  src_e         src_q, src_d;
  src_e         last_q, last_d;
  logic [127:0] op_q, op_d;
  logic [127:0] res_q, res_d;

  logic arb_en;
  logic rnd_win;
  logic key_win;
  logic rnd_gnt;
  logic key_gnt;

  // Round-robin arbitration; only open in IDLE/DONE and never during reset
  always_comb begin
    arb_en  = !rst && (state_q != ST_EVAL);
    rnd_win = bus.rnd_req && (!bus.key_req || (last_q == SRC_KEY));
    key_win = bus.key_req && !rnd_win;
    rnd_gnt = arb_en && rnd_win;
    key_gnt = arb_en && key_win;
  end

  // Next-state, operand capture and result capture
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (rnd_gnt) begin
          op_d    = bus.rnd_data;
          src_d   = SRC_RND;
          last_d  = SRC_RND;
          state_d = ST_EVAL;
        end else if (key_gnt) begin
          op_d    = {96'h0, bus.key_word};
          src_d   = SRC_KEY;
          last_d  = SRC_KEY;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        res_d   = bus.sb_out;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_RND;
      last_q  <= SRC_KEY;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Output decode; valid is masked by rst so a reset in DONE drops the pulse
  always_comb begin
    bus.rnd_grant  = rnd_gnt;
    bus.key_grant  = key_gnt;
    bus.busy       = (state_q == ST_EVAL);
    bus.sb_in      = (state_q == ST_EVAL) ? op_q : '0;
    bus.rnd_valid  = !rst && (state_q == ST_DONE) && (src_q == SRC_RND);
    bus.key_valid  = !rst && (state_q == ST_DONE) && (src_q == SRC_KEY);
    bus.rnd_result = res_q;
    bus.key_result = res_q[31:0];
  end

endmodule

// File: tb/tb_s_box_arbiter.sv
// Directed bench for s_box_arbiter with an AES S-box model on sb_in/sb_out.
module tb_s_box_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  s_box_arbiter_if bus ();

  s_box_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Combinational S-box bank
  always_comb begin
    bus.sb_out = '0;
    for (int i = 0; i < 16; i++)
      bus.sb_out[i*8 +: 8] = sbox[bus.sb_in[i*8 +: 8]];
  end

  localparam logic [127:0] RND_ZERO_RES = 128'h63636363636363636363636363636363;
  localparam logic [127:0] RND_VEC      = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] RND_VEC_RES  = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [31:0]  KEY_VEC      = 32'h000153FF;
  localparam logic [31:0]  KEY_VEC_RES  = 32'h637CED16;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  logic [4:0] obs;
  logic [4:0] exp_tab [0:9];

  initial begin
    bus.rnd_req  = 1'b0;
    bus.rnd_data = '0;
    bus.key_req  = 1'b0;
    bus.key_word = '0;

    // Reset state, including grant suppression while rst is high
    rst = 1'b1;
    next_cycle();
    bus.rnd_req = 1'b1;
    #1;
    check_eq("rst_grant_suppressed", {126'h0, bus.rnd_grant, bus.key_grant}, '0);
    check_eq("rst_busy_valid", {125'h0, bus.busy, bus.rnd_valid, bus.key_valid}, '0);
    check_eq("rst_rnd_result", bus.rnd_result, '0);
    check_eq("rst_key_result", {96'h0, bus.key_result}, '0);
    check_eq("rst_sb_in", bus.sb_in, '0);
    next_cycle();
    rst = 1'b0;

    // Round operand 0: grant, busy, valid with all-63 result
    bus.rnd_data = '0;
    #1;
    check_eq("t1_rnd_grant", {126'h0, bus.rnd_grant, bus.key_grant}, 128'h2);
    next_cycle();
    bus.rnd_req = 1'b0;
    #1;
    check_eq("t1_busy", {127'h0, bus.busy}, 128'h1);
    check_eq("t1_eval_no_valid", {126'h0, bus.rnd_valid, bus.key_valid}, '0);
    next_cycle();
    #1;
    check_eq("t1_valids", {126'h0, bus.rnd_valid, bus.key_valid}, 128'h2);
    check_eq("t1_rnd_result", bus.rnd_result, RND_ZERO_RES);
    next_cycle();
    #1;
    check_eq("t1_idle_no_valid", {125'h0, bus.busy, bus.rnd_valid, bus.key_valid}, '0);
    check_eq("t1_result_hold", bus.rnd_result, RND_ZERO_RES);

    // Key word: only low 32 bits reach the S-box
    bus.key_req  = 1'b1;
    bus.key_word = KEY_VEC;
    #1;
    check_eq("t2_key_grant", {126'h0, bus.rnd_grant, bus.key_grant}, 128'h1);
    next_cycle();
    bus.key_req = 1'b0;
    #1;
    check_eq("t2_sb_in", bus.sb_in, {96'h0, KEY_VEC});
    next_cycle();
    #1;
    check_eq("t2_valids", {126'h0, bus.rnd_valid, bus.key_valid}, 128'h1);
    check_eq("t2_key_result", {96'h0, bus.key_result}, {96'h0, KEY_VEC_RES});

    // Both requesters held: alternation RND, KEY, RND, KEY from reset
    // exp bits: {rnd_grant, key_grant, rnd_valid, key_valid, busy}
    do_reset();
    exp_tab = '{5'b10000, 5'b00001, 5'b01100, 5'b00001, 5'b10010,
                5'b00001, 5'b01100, 5'b00001, 5'b00010, 5'b00000};
    bus.rnd_data = '0;
    bus.key_word = KEY_VEC;
    for (int c = 0; c < 10; c++) begin
      bus.rnd_req = (c < 8);
      bus.key_req = (c < 8);
      #1;
      obs = {bus.rnd_grant, bus.key_grant, bus.rnd_valid, bus.key_valid, bus.busy};
      check_eq($sformatf("t3_c%0d", c), {123'h0, obs}, {123'h0, exp_tab[c]});
      check_eq($sformatf("t3_one_grant_c%0d", c), {127'h0, bus.rnd_grant & bus.key_grant}, '0);
      if (exp_tab[c][2]) check_eq($sformatf("t3_rres_c%0d", c), bus.rnd_result, RND_ZERO_RES);
      if (exp_tab[c][1]) check_eq($sformatf("t3_kres_c%0d", c), {96'h0, bus.key_result}, {96'h0, KEY_VEC_RES});
      next_cycle();
    end

    // Key request during round EVAL waits for DONE
    bus.rnd_req  = 1'b1;
    bus.rnd_data = RND_VEC;
    #1;
    check_eq("t4_rnd_grant", {126'h0, bus.rnd_grant, bus.key_grant}, 128'h2);
    next_cycle();
    bus.rnd_req  = 1'b0;
    bus.key_req  = 1'b1;
    bus.key_word = KEY_VEC;
    #1;
    check_eq("t4_eval_no_grant", {125'h0, bus.rnd_grant, bus.key_grant, bus.busy}, 128'h1);
    next_cycle();
    #1;
    check_eq("t4_done", {125'h0, bus.rnd_valid, bus.key_valid, bus.key_grant}, 128'h5);
    check_eq("t4_rnd_result", bus.rnd_result, RND_VEC_RES);
    next_cycle();
    bus.key_req = 1'b0;
    #1;
    check_eq("t4_key_busy", {127'h0, bus.busy}, 128'h1);
    next_cycle();
    #1;
    check_eq("t4_key_valid", {126'h0, bus.rnd_valid, bus.key_valid}, 128'h1);
    check_eq("t4_key_result", {96'h0, bus.key_result}, {96'h0, KEY_VEC_RES});
    next_cycle();

    // Reset during round EVAL discards the operation
    bus.rnd_req  = 1'b1;
    bus.rnd_data = RND_VEC;
    #1;
    check_eq("t5_rnd_grant", {126'h0, bus.rnd_grant, bus.key_grant}, 128'h2);
    next_cycle();
    bus.rnd_req = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.rnd_req  = 1'b1;
    bus.rnd_data = '0;
    #1;
    check_eq("t5_post_rst_flags", {125'h0, bus.busy, bus.rnd_valid, bus.key_valid}, '0);
    check_eq("t5_post_rst_rres", bus.rnd_result, '0);
    check_eq("t5_post_rst_kres", {96'h0, bus.key_result}, '0);
    check_eq("t5_post_rst_sb_in", bus.sb_in, '0);
    check_eq("t5_regrant", {126'h0, bus.rnd_grant, bus.key_grant}, 128'h2);
    next_cycle();
    bus.rnd_req = 1'b0;
    #1;
    check_eq("t5_busy", {127'h0, bus.busy}, 128'h1);
    next_cycle();
    #1;
    check_eq("t5_valid", {126'h0, bus.rnd_valid, bus.key_valid}, 128'h2);
    check_eq("t5_result", bus.rnd_result, RND_ZERO_RES);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
